// File: rtl/pcie_link_partner_model_if.sv
// Lane and link-status bundle of one link partner.
// The slave side is the model; the master side is whatever wires or observes it.
interface pcie_link_partner_model_if #(
   parameter int LINK_WIDTH = 8
);
   logic [LINK_WIDTH-1:0] pci_exp_txp;
   logic [LINK_WIDTH-1:0] pci_exp_txn;
   logic [LINK_WIDTH-1:0] pci_exp_rxp;
   logic [LINK_WIDTH-1:0] pci_exp_rxn;
   logic                  link_up;
   logic [4:0]            link_width;
   logic [2:0]            link_speed;
   logic [1:0]            ltssm_state;
   logic [2:0]            max_payload;

   modport slave (
      output pci_exp_txp, pci_exp_txn, link_up, link_width, link_speed, ltssm_state, max_payload,
      input  pci_exp_rxp, pci_exp_rxn
   );

   modport master (
      input  pci_exp_txp, pci_exp_txn, link_up, link_width, link_speed, ltssm_state, max_payload,
      output pci_exp_rxp, pci_exp_rxn
   );
endinterface

// File: rtl/pcie_link_partner_model.sv
// Simplified PCIe link partner: reduced LTSSM (Detect/Polling/Config/L0) over
// 1-bit-per-clock differential lanes; two instances cross-connect to train a link.
module pcie_link_partner_model #(
   parameter int         LINK_WIDTH                   = 8,
   parameter logic [2:0] LINK_SPEED                   = 3'h4,
   parameter logic [2:0] PF0_DEV_CAP_MAX_PAYLOAD_SIZE = 3'b010
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   pcie_link_partner_model_if.slave lnk
);
   localparam logic [15:0] TS1  = 16'hBC4A;
   localparam logic [15:0] TS2  = 16'hBC45;
   localparam logic        PH_A = 1'b0;
   localparam logic        PH_B = 1'b1;

   typedef enum logic [1:0] {
      ST_DETECT  = 2'd0,
      ST_POLLING = 2'd1,
      ST_CONFIG  = 2'd2,
      ST_L0      = 2'd3
   } state_e;

   // Largest power-of-two prefix of lanes that all saw training sets.
   function automatic logic [4:0] calc_width(input logic [LINK_WIDTH-1:0] ok);
      logic       run;
      logic [4:0] w;
      run = 1'b1;
      w   = 5'd0;
      for (int i = 0; i < LINK_WIDTH; i++) begin
         run = run & ok[i];
         if (run && (((i + 1) & i) == 32'sd0)) w = 5'(i + 1);
         else                                  w = w;
      end
      return w;
   endfunction

   function automatic logic [LINK_WIDTH-1:0] lane_mask(input logic [4:0] w);
      logic [LINK_WIDTH-1:0] m;
      for (int i = 0; i < LINK_WIDTH; i++) m[i] = (i < int'(w));
      return m;
   endfunction

   logic [1:0]            rst_sync_q;
   logic                  rst_n_s;
   state_e                state_q, state_d;
   logic                  phase_q, phase_d;
   logic [11:0]           timer_q, timer_d;
   logic [3:0]            bit_idx_q, bit_idx_d;
   logic [4:0]            sent_q, sent_d;
   logic [5:0]            idle_q, idle_d;
   logic [4:0]            width_q, width_d;
   logic [LINK_WIDTH-1:0] present_q, present_d;
   logic [15:0]           sh_q [LINK_WIDTH];
   logic [15:0]           sh_d [LINK_WIDTH];
   logic [3:0]            match_q [LINK_WIDTH];
   logic [3:0]            match_d [LINK_WIDTH];
   logic [LINK_WIDTH-1:0] txp_q, txp_d, txn_q, txn_d;
   logic                  link_up_q, link_up_d;
   logic [2:0]            link_speed_q, link_speed_d;
   logic [LINK_WIDTH-1:0] active_s, hit_s, ok_s;
   logic                  entry_s, boundary_s;

   assign active_s = lnk.pci_exp_rxp ^ lnk.pci_exp_rxn;

   // Reset synchronizer: assertion is immediate, release waits two clocks.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rst_sync_q <= 2'b00;
      else            rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_s = rst_sync_q[1];

   // Next-state, counters and registered-output values.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      timer_d    = timer_q + 12'd1;
      bit_idx_d  = bit_idx_q + 4'd1;
      width_d    = width_q;
      entry_s    = 1'b0;
      hit_s      = '0;
      ok_s       = '0;
      boundary_s = (bit_idx_q == 4'd15);
      if (boundary_s && (sent_q != 5'd31)) sent_d = sent_q + 5'd1;
      else                                 sent_d = sent_q;
      if (state_q == ST_DETECT) present_d = present_q | active_s;
      else                      present_d = present_q;
      if ((state_q == ST_L0) && !active_s[0]) idle_d = idle_q + 6'd1;
      else                                    idle_d = 6'd0;

      for (int i = 0; i < LINK_WIDTH; i++) begin
         if (active_s[i]) sh_d[i] = {sh_q[i][14:0], lnk.pci_exp_rxp[i]};
         else             sh_d[i] = sh_q[i];
         hit_s[i] = active_s[i] &&
                    (((sh_d[i] == TS2) && ((state_q == ST_POLLING) || (state_q == ST_CONFIG))) ||
                     ((sh_d[i] == TS1) && (state_q == ST_POLLING)));
         if (hit_s[i] && (match_q[i] != 4'd15)) match_d[i] = match_q[i] + 4'd1;
         else                                   match_d[i] = match_q[i];
         ok_s[i] = (match_d[i] != 4'd0);
      end

      case (state_q)
         ST_DETECT: begin
            if (timer_q == 12'd31) begin
               timer_d = 12'd0;
               if (phase_q == PH_A) begin
                  phase_d = PH_B;
               end else if (present_d[0]) begin
                  state_d = ST_POLLING;
                  entry_s = 1'b1;
               end else begin
                  phase_d   = PH_A;
                  present_d = '0;
               end
            end else begin
               phase_d = phase_q;
            end
         end
         ST_POLLING, ST_CONFIG: begin
            // Residency timeout outranks a same-cycle exit.
            if (timer_q == 12'd4095) begin
               state_d = ST_DETECT;
               entry_s = 1'b1;
            end else if (boundary_s && (match_d[0] >= 4'd8) && (sent_d >= 5'd16)) begin
               state_d = (state_q == ST_POLLING) ? ST_CONFIG : ST_L0;
               entry_s = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_L0: begin
            if (!active_s[0] && (idle_q == 6'd63)) begin
               state_d = ST_DETECT;
               entry_s = 1'b1;
            end else begin
               state_d = ST_L0;
            end
         end
         default: begin
            state_d = ST_DETECT;
            entry_s = 1'b1;
         end
      endcase

      if (entry_s) begin
         timer_d   = 12'd0;
         bit_idx_d = 4'd0;
         sent_d    = 5'd0;
         idle_d    = 6'd0;
         phase_d   = PH_A;
         present_d = '0;
         for (int i = 0; i < LINK_WIDTH; i++) match_d[i] = 4'd0;
      end else begin
         timer_d = timer_d;
      end

      if ((state_d == ST_L0) && (state_q == ST_CONFIG)) width_d = calc_width(ok_s);
      else if (state_d != ST_L0)                        width_d = 5'd0;
      else                                              width_d = width_q;

      // Lane drive follows the next state so tx lines up with ltssm_state.
      txp_d = '0;
      txn_d = '0;
      case (state_d)
         ST_DETECT: begin
            if (phase_d == PH_B) txp_d = {LINK_WIDTH{1'b1}};
            else                 txp_d = '0;
         end
         ST_POLLING: begin
            txp_d = {LINK_WIDTH{TS1[~bit_idx_d]}};
            txn_d = ~txp_d;
         end
         ST_CONFIG: begin
            txp_d = {LINK_WIDTH{TS2[~bit_idx_d]}};
            txn_d = ~txp_d;
         end
         ST_L0: begin
            txn_d = lane_mask(width_d);
         end
         default: begin
            txp_d = '0;
            txn_d = '0;
         end
      endcase
      link_up_d    = (state_d == ST_L0);
      link_speed_d = (state_d == ST_L0) ? LINK_SPEED : 3'd0;
   end

   // State, counters, receive shifters and registered outputs.
   always_ff @(posedge sys_clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_q      <= ST_DETECT;
         phase_q      <= PH_A;
         timer_q      <= 12'd0;
         bit_idx_q    <= 4'd0;
         sent_q       <= 5'd0;
         idle_q       <= 6'd0;
         width_q      <= 5'd0;
         present_q    <= '0;
         txp_q        <= '0;
         txn_q        <= '0;
         link_up_q    <= 1'b0;
         link_speed_q <= 3'd0;
         for (int i = 0; i < LINK_WIDTH; i++) begin
            sh_q[i]    <= 16'd0;
            match_q[i] <= 4'd0;
         end
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         timer_q      <= timer_d;
         bit_idx_q    <= bit_idx_d;
         sent_q       <= sent_d;
         idle_q       <= idle_d;
         width_q      <= width_d;
         present_q    <= present_d;
         txp_q        <= txp_d;
         txn_q        <= txn_d;
         link_up_q    <= link_up_d;
         link_speed_q <= link_speed_d;
         for (int i = 0; i < LINK_WIDTH; i++) begin
            sh_q[i]    <= sh_d[i];
            match_q[i] <= match_d[i];
         end
      end
   end

   assign lnk.pci_exp_txp = txp_q;
   assign lnk.pci_exp_txn = txn_q;
   assign lnk.link_up     = link_up_q;
   assign lnk.link_width  = width_q;
   assign lnk.link_speed  = link_speed_q;
   assign lnk.ltssm_state = state_q;
   assign lnk.max_payload = PF0_DEV_CAP_MAX_PAYLOAD_SIZE;
endmodule

// File: tb/tb_pcie_link_partner_model.sv
// Directed bench: two cross-connected link partners (A and B) with per-lane
// connection masks and a TS1-only pattern source for partner A.
module tb_pcie_link_partner_model;
   localparam int          W   = 8;
   localparam logic [15:0] TS1 = 16'hBC4A;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic       up;
      logic [4:0] w;
      logic [2:0] sp;
   } exp_t;

   logic           sys_clk = 1'b0;
   logic           sys_rst_n = 1'b0;
   logic [W-1:0]   a_conn = '1;
   logic [W-1:0]   b_conn = '1;
   logic [W-1:0]   gen_mask = '0;
   logic [3:0]     gen_cnt = 4'd0;
   logic [W-1:0]   gen_p, gen_n;
   logic [15:0]    ts1_v = TS1;
   exp_t           sb_q[$];
   int             n_assert = 0;
   int             n_fail = 0;

   pcie_link_partner_model_if #(.LINK_WIDTH(W)) ifa ();
   pcie_link_partner_model_if #(.LINK_WIDTH(W)) ifb ();

   pcie_link_partner_model #(.LINK_WIDTH(W)) dut_a (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lnk(ifa));
   pcie_link_partner_model #(.LINK_WIDTH(W)) dut_b (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lnk(ifb));

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) gen_cnt <= gen_cnt + 4'd1;
   assign gen_p = {W{ts1_v[~gen_cnt]}};
   assign gen_n = ~gen_p;

   assign ifa.pci_exp_rxp = (ifb.pci_exp_txp & a_conn) | (gen_p & gen_mask);
   assign ifa.pci_exp_rxn = (ifb.pci_exp_txn & a_conn) | (gen_n & gen_mask);
   assign ifb.pci_exp_rxp = ifa.pci_exp_txp & b_conn;
   assign ifb.pci_exp_rxn = ifa.pci_exp_txn & b_conn;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [1:0] st, input logic up,
                           input logic [4:0] w, input logic [2:0] sp);
      exp_t e;
      e.tag = tag; e.st = st; e.up = up; e.w = w; e.sp = sp;
      sb_q.push_back(e);
   endtask

   task automatic pop_chk_a();
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, ".state"}, 32'(ifa.ltssm_state), 32'(e.st));
      chk({e.tag, ".up"},    32'(ifa.link_up),     32'(e.up));
      chk({e.tag, ".width"}, 32'(ifa.link_width),  32'(e.w));
      chk({e.tag, ".speed"}, 32'(ifa.link_speed),  32'(e.sp));
   endtask

   task automatic wait_state_a(input string tag, input logic [1:0] st, input int budget);
      int n;
      n = 0;
      while ((ifa.ltssm_state !== st) && (n < budget)) begin
         @(negedge sys_clk);
         n++;
      end
      chk({tag, ".reached"}, 32'(ifa.ltssm_state === st), 32'd1);
   endtask

   task automatic pulse_reset(input logic [W-1:0] ac, input logic [W-1:0] bc, input logic [W-1:0] gm);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      a_conn = ac; b_conn = bc; gen_mask = gm;
      repeat (3) @(negedge sys_clk);
      #2 sys_rst_n = 1'b1;
   endtask

   initial begin
      int run, runs, bad_run, bad_stay, cnt;
      logic prev;

      // Full x8 link trains from a common reset release.
      #23 sys_rst_n = 1'b1;
      wait_state_a("link8", 2'd3, 600);
      push_exp("link8", 2'd3, 1'b1, 5'd8, 3'd4);
      pop_chk_a();
      chk("link8.b_state", 32'(ifb.ltssm_state), 32'd3);
      chk("link8.b_width", 32'(ifb.link_width), 32'd8);
      chk("link8.mps", 32'(ifa.max_payload), 32'd2);
      chk("link8.txp", 32'(ifa.pci_exp_txp), 32'h00);
      chk("link8.txn", 32'(ifa.pci_exp_txn), 32'hFF);

      // Partner halted in L0: 63 idle clocks keep L0, the 64th drops to DETECT.
      @(posedge sys_clk);
      #1 a_conn = '0;
      repeat (63) @(posedge sys_clk);
      #1 push_exp("halt63", 2'd3, 1'b1, 5'd8, 3'd4);
      pop_chk_a();
      @(posedge sys_clk);
      #1 push_exp("halt64", 2'd0, 1'b0, 5'd0, 3'd0);
      pop_chk_a();

      // Only lanes 0-3 cross-connected: x4 link, lanes 4-7 electrically idle.
      pulse_reset(8'h0F, 8'h0F, 8'h00);
      wait_state_a("link4", 2'd3, 600);
      push_exp("link4", 2'd3, 1'b1, 5'd4, 3'd4);
      pop_chk_a();
      chk("link4.txp", 32'(ifa.pci_exp_txp), 32'h00);
      chk("link4.txn", 32'(ifa.pci_exp_txn), 32'h0F);
      chk("link4.b_width", 32'(ifb.link_width), 32'd4);

      // No partner: DETECT forever with alternating 32-cycle idle/beacon on tx.
      pulse_reset(8'h00, 8'hFF, 8'h00);
      run = 0; runs = 0; bad_run = 0; bad_stay = 0;
      prev = ifa.pci_exp_txp[0];
      for (int c = 0; c < 10000; c++) begin
         @(negedge sys_clk);
         if ((ifa.ltssm_state !== 2'd0) || (ifa.link_up !== 1'b0) || (ifa.pci_exp_txn !== 8'h00) ||
             ((ifa.pci_exp_txp !== 8'h00) && (ifa.pci_exp_txp !== 8'hFF)))
            bad_stay++;
         if (ifa.pci_exp_txp[0] === prev) begin
            run++;
         end else begin
            if ((runs > 0) && (run != 32)) bad_run++;
            runs++;
            run = 1;
            prev = ifa.pci_exp_txp[0];
         end
      end
      chk("detect.stay", 32'(bad_stay), 32'd0);
      chk("detect.run_len", 32'(bad_run), 32'd0);
      chk("detect.toggles", 32'(runs >= 300), 32'd1);
      push_exp("detect", 2'd0, 1'b0, 5'd0, 3'd0);
      pop_chk_a();

      // TS1-only partner: POLLING, CONFIG, then a 4096-cycle CONFIG timeout.
      pulse_reset(8'h00, 8'hFF, 8'hFF);
      wait_state_a("ts1.poll", 2'd1, 200);
      wait_state_a("ts1.cfg", 2'd2, 1000);
      cnt = 0;
      while ((ifa.ltssm_state === 2'd2) && (cnt < 5000)) begin
         cnt++;
         @(negedge sys_clk);
      end
      chk("ts1.cfg_cycles", 32'(cnt), 32'd4096);
      push_exp("ts1.timeout", 2'd0, 1'b0, 5'd0, 3'd0);
      pop_chk_a();

      // Asynchronous reset in L0, then relink.
      pulse_reset(8'hFF, 8'hFF, 8'h00);
      wait_state_a("pre_rst", 2'd3, 600);
      @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1 push_exp("async_rst", 2'd0, 1'b0, 5'd0, 3'd0);
      pop_chk_a();
      chk("async_rst.txp", 32'(ifa.pci_exp_txp), 32'h00);
      chk("async_rst.txn", 32'(ifa.pci_exp_txn), 32'h00);
      #4 sys_rst_n = 1'b1;
      wait_state_a("relink", 2'd3, 600);
      push_exp("relink", 2'd3, 1'b1, 5'd8, 3'd4);
      pop_chk_a();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
